ripple_acc_stream: RTL and testbench
====================================

# ripple_acc_stream

Handshaked packet accumulator that sits upstream of the team's DATA_WIDTH-bit ripple-carry adder and consumes its sum/carry-out. For each incoming packet of words, it feeds the running accumulator and the current word into the adder with carry-in 0. It registers the adder's sum back into the accumulator and counts carry-outs. On the packet's last word it presents the modular sum, the saturating carry count and the saturating word count on a handshaked output.

## Interface
- DATA_WIDTH, 4, width of input words, accumulator and adder
- CNT_WIDTH, 4, width of the carry and word counters (both saturate at 2^CNT_WIDTH-1)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- dataIn_data  in  DATA_WIDTH  packet word
- dataIn_last  in  1  marks final word of packet
- dataIn_vld  in  1  input word valid
- dataIn_rd  out  1  block ready to accept input word
- dataOut_sum  out  DATA_WIDTH  packet sum modulo 2^DATA_WIDTH
- dataOut_carries  out  CNT_WIDTH  number of adder carry-outs in packet, saturating
- dataOut_len  out  CNT_WIDTH  number of words in packet, saturating
- dataOut_vld  out  1  result valid
- dataOut_rd  in  1  downstream ready

## Operation
- Input transfer occurs when dataIn_vld && dataIn_rd; output transfer occurs when dataOut_vld && dataOut_rd.
- Internal registers:
  - acc (DATA_WIDTH)
  - carries (CNT_WIDTH)
  - len (CNT_WIDTH)
  - result registers sum_q/carries_q/len_q
  - state ∈ {ACC, OUT}
- Adder connection: a=acc, b=dataIn_data, ci=0, giving s, co.
- On input transfer, not last:
  - acc <= s
  - carries <= sat(carries+co)
  - len <= sat(len+1)
- On input transfer with dataIn_last=1:
  - sum_q <= s
  - carries_q <= sat(carries+co)
  - len_q <= sat(len+1)
  - acc, carries and len <= 0
  - state <= OUT
- sat(x) clamps to 2^CNT_WIDTH-1 and never wraps.
- State ACC:
  - dataOut_vld=0, dataIn_rd=1.
- State OUT:
  - dataOut_vld=1; dataOut_* driven from the result registers.
  - dataIn_rd = dataOut_rd, so the next packet's first word may be accepted in the same cycle the result is consumed.
  - On output transfer with no last-word input transfer: state <= ACC.
  - On output transfer and a simultaneous input transfer with last=1: result registers are reloaded and state stays OUT (back-to-back single-word packets at full rate).
  - Without output transfer: no input is accepted, and all outputs stay stable.
- dataOut_* are don't-care while dataOut_vld=0, but they must hold the last result, not garbage, for waveform readability.
- Reset: while rst_n=0 at a clock edge:
  - state <= ACC; acc, carries, len and result registers <= 0
  - dataOut_vld=0; dataIn_rd=0 in any cycle where rst_n=0
- Reset mid-packet discards the partial packet; no result is emitted for it.

## Timing
- Latency: dataOut_vld rises in the cycle after the last-word input transfer.
- Throughput:
  - one word per cycle within a packet
  - packets of ≥1 word at one word per cycle, provided dataOut_rd is held high
- No combinational path from dataIn_vld to dataIn_rd.
- Combinational path dataOut_rd -> dataIn_rd exists only in OUT.
- dataOut_* are registered outputs.

## Test plan
- Single-word packet 0x9/last -> next cycle dataOut_vld=1, sum=0x9, carries=0, len=1; with dataOut_rd=1 the block returns to ACC.
- Packet 0xF, 0x1, 0x3(last) -> sum=0x3, carries=1, len=3.
- 18 words of 0xF, the last flagged -> sum=0xE, carries=15 (true 16, saturated), len=15 (true 18, saturated).
- Result pending with dataOut_rd=0 for 3 cycles -> dataIn_rd=0, outputs stable and vld held. Then dataOut_rd=1 together with input 0x5/last -> same-cycle transfer of both, next cycle sum=0x5, len=1, vld stays 1.
- rst_n=0 for one cycle after words 0x7, 0x8 of an unfinished packet, then packet 0x2(last) -> sum=0x2, carries=0, len=1. dataIn_rd=0 and dataOut_vld=0 during reset.
- Random vld/rd stimulus, 1000 packets -> scoreboard matches the reference model (mod-2^DATA_WIDTH sum, saturating counters), with no lost or duplicated results.

Source files
------------

// File: rtl/ripple_acc_stream.sv
// Handshaked packet accumulator: sums each packet through a ripple-carry adder,
// counting carry-outs and words, and hands the result downstream per packet.
module ripple_acc_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataIn_data,
  input  logic                  dataIn_last,
  input  logic                  dataIn_vld,
  output logic                  dataIn_rd,
  output logic [DATA_WIDTH-1:0] dataOut_sum,
  output logic [CNT_WIDTH-1:0]  dataOut_carries,
  output logic [CNT_WIDTH-1:0]  dataOut_len,
  output logic                  dataOut_vld,
  input  logic                  dataOut_rd
);

  typedef enum logic {ACC, OUT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] acc_reg, sum_reg;
  logic [CNT_WIDTH-1:0]  carries_reg, len_reg, carries_q_reg, len_q_reg;

  logic [DATA_WIDTH-1:0] add_s;
  logic [DATA_WIDTH:0]   add_c;
  logic                  add_co;
  logic [CNT_WIDTH-1:0]  carries_next, len_next;
  logic                  in_xfer, out_xfer;

  // Ripple-carry adder, carry-in tied low.
  assign add_c[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rca
      assign add_s[gi]   = acc_reg[gi] ^ dataIn_data[gi] ^ add_c[gi];
      assign add_c[gi+1] = (acc_reg[gi] & dataIn_data[gi]) |
                           (add_c[gi] & (acc_reg[gi] ^ dataIn_data[gi]));
    end
  endgenerate
  assign add_co = add_c[DATA_WIDTH];

  assign carries_next = (add_co && carries_reg != CNT_MAX) ? carries_reg + CNT_WIDTH'(1)
                                                           : carries_reg;
  assign len_next     = (len_reg != CNT_MAX) ? len_reg + CNT_WIDTH'(1) : len_reg;

  assign in_xfer  = dataIn_vld && dataIn_rd;
  assign out_xfer = dataOut_vld && dataOut_rd;

  // In OUT the input is only opened while the pending result is being taken.
  always_comb begin
    dataIn_rd   = 1'b0;
    dataOut_vld = 1'b0;
    state_next  = state_reg;
    if (rst_n) begin
      case (state_reg)
        ACC: dataIn_rd = 1'b1;
        OUT: begin
          dataOut_vld = 1'b1;
          dataIn_rd   = dataOut_rd;
        end
        default: dataIn_rd = 1'b0;
      endcase
    end
    if (in_xfer && dataIn_last) begin
      state_next = OUT;
    end else if (out_xfer) begin
      state_next = ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ACC;
      acc_reg       <= '0;
      carries_reg   <= '0;
      len_reg       <= '0;
      sum_reg       <= '0;
      carries_q_reg <= '0;
      len_q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (in_xfer) begin
        if (dataIn_last) begin
          sum_reg       <= add_s;
          carries_q_reg <= carries_next;
          len_q_reg     <= len_next;
          acc_reg       <= '0;
          carries_reg   <= '0;
          len_reg       <= '0;
        end else begin
          acc_reg     <= add_s;
          carries_reg <= carries_next;
          len_reg     <= len_next;
        end
      end
    end
  end

  assign dataOut_sum     = sum_reg;
  assign dataOut_carries = carries_q_reg;
  assign dataOut_len     = len_q_reg;

endmodule

// File: tb/tb_ripple_acc_stream.sv
// Bench for ripple_acc_stream: packet-level model plus directed literal checks.
module tb_ripple_acc_stream;

  localparam int DW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rd;
  logic [DW-1:0] out_sum;
  logic [CW-1:0] out_car;
  logic [CW-1:0] out_len;
  logic          out_vld;
  logic          out_rd = 1'b0;

  always #5 clk = ~clk;

  ripple_acc_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dataIn_data(in_data), .dataIn_last(in_last), .dataIn_vld(in_vld), .dataIn_rd(in_rd),
    .dataOut_sum(out_sum), .dataOut_carries(out_car), .dataOut_len(out_len),
    .dataOut_vld(out_vld), .dataOut_rd(out_rd)
  );

  typedef struct {int sum; int car; int len;} res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   pkt_total = 0;
  int   pkt_words = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Packet-level model: the sum is the true total mod 2^DW, every crossing of a
  // multiple of 2^DW is one carry-out, both counters clamp.
  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      chk("rst_in_rd", int'(in_rd), 0);
      chk("rst_out_vld", int'(out_vld), 0);
      exp_q.delete();
      pkt_total = 0;
      pkt_words = 0;
    end else begin
      chk("out_vld", int'(out_vld), int'(exp_q.size() > 0));
      chk("in_rd", int'(in_rd), int'(exp_q.size() == 0 || out_rd));
      if (exp_q.size() > 0) begin
        chk("out_sum", int'(out_sum), exp_q[0].sum);
        chk("out_carries", int'(out_car), exp_q[0].car);
        chk("out_len", int'(out_len), exp_q[0].len);
      end
      if (out_vld && out_rd) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else chk("unexpected_result", 1, 0);
        r.sum = int'(out_sum); r.car = int'(out_car); r.len = int'(out_len);
        obs_q.push_back(r);
      end
      if (in_vld && in_rd) begin
        pkt_total += int'(in_data);
        pkt_words++;
        if (in_last) begin
          r.sum = pkt_total % (1 << DW);
          r.car = (pkt_total / (1 << DW) > CMAX) ? CMAX : pkt_total / (1 << DW);
          r.len = (pkt_words > CMAX) ? CMAX : pkt_words;
          exp_q.push_back(r);
          pkt_total = 0;
          pkt_words = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_vld = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_rd && n < 200);
    chk("send_accepted", int'(in_rd), 1);
    step();
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_obs(input string name, input int s, input int c, input int l);
    res_t r;
    int n = 0;
    while (obs_q.size() == 0 && n < 30) begin
      step();
      n++;
    end
    chk({name, "_present"}, int'(obs_q.size() > 0), 1);
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      chk({name, "_sum"}, r.sum, s);
      chk({name, "_carries"}, r.car, c);
      chk({name, "_len"}, r.len, l);
      $display("result %s: sum=%0d carries=%0d len=%0d", name, r.sum, r.car, r.len);
    end
  endtask

  initial begin
    int pkts, plen, widx, cycles;
    logic [DW-1:0] w;

    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_sum", int'(out_sum), 0);
    chk("reset_len", int'(out_len), 0);
    step();

    // single-word packet
    out_rd = 1'b1;
    send(4'h9, 1'b1);
    @(negedge clk);
    chk("t1_vld_next_cycle", int'(out_vld), 1);
    step();
    expect_obs("t1", 9, 0, 1);
    @(negedge clk);
    chk("t1_back_to_acc", int'(out_vld), 0);
    step();

    // one carry
    send(4'hF, 1'b0); send(4'h1, 1'b0); send(4'h3, 1'b1);
    expect_obs("t2", 3, 1, 3);

    // saturation of both counters
    for (int i = 0; i < 18; i++) send(4'hF, (i == 17) ? 1'b1 : 1'b0);
    expect_obs("t3", 14, 15, 15);

    // stall with result pending, then simultaneous transfer both ways
    out_rd = 1'b0;
    send(4'h1, 1'b1);
    in_data = 4'h5; in_last = 1'b1; in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_in_rd", int'(in_rd), 0);
      chk("t4_stall_vld", int'(out_vld), 1);
      chk("t4_stall_sum", int'(out_sum), 1);
      step();
    end
    out_rd = 1'b1;
    @(negedge clk);
    chk("t4_same_cycle_in_rd", int'(in_rd), 1);
    step();
    in_vld = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("t4_vld_held", int'(out_vld), 1);
    chk("t4_sum", int'(out_sum), 5);
    chk("t4_len", int'(out_len), 1);
    step();
    expect_obs("t4a", 1, 0, 1);
    expect_obs("t4b", 5, 0, 1);

    // reset mid-packet
    send(4'h7, 1'b0); send(4'h8, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_in_rd", int'(in_rd), 0);
    chk("t5_rst_vld", int'(out_vld), 0);
    step();
    rst_n = 1'b1;
    send(4'h2, 1'b1);
    expect_obs("t5", 2, 0, 1);

    // random traffic, 1000 packets
    obs_q.delete();
    pkts = 0; widx = 0; cycles = 0;
    plen = $urandom_range(1, 10);
    w = DW'($urandom);
    while (pkts < 1000 && cycles < 60000) begin
      out_rd = ($urandom_range(0, 3) != 0);
      in_vld = ($urandom_range(0, 3) != 0);
      in_data = w;
      in_last = (widx == plen - 1);
      @(negedge clk);
      if (in_vld && in_rd) begin
        widx++;
        w = DW'($urandom);
        if (widx == plen) begin
          pkts++;
          widx = 0;
          plen = (pkts % 50 == 0) ? 18 : $urandom_range(1, 10);
        end
      end
      step();
      cycles++;
    end
    in_vld = 1'b0; in_last = 1'b0; out_rd = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("random_all_packets_sent", pkts, 1000);
    chk("random_results_seen", obs_q.size(), 1000);
    chk("random_none_pending", exp_q.size(), 0);
    $display("random phase: %0d packets, %0d results", pkts, obs_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
